// File: rtl/registro_salidas_alu.sv
// Registered ALU output stage: a DEPTH-entry FIFO holding the ALU result and
// its carry/cero/negativo/desbordamiento flags behind valid/ready handshakes.
// Optional feature macro ALU_STICKY_FLAGS_EN: when defined, salida_sticky
// accumulates the flags of every popped entry until clear_sticky; when
// undefined, salida_sticky is tied to zero and no sticky register exists.
module registro_salidas_alu #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WIDTH-1:0]           in_result,
  input  logic                       in_carry,
  input  logic                       in_cero,
  input  logic                       in_negativo,
  input  logic                       in_desbordamiento,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WIDTH-1:0]           salida_result,
  output logic                       salida_carry,
  output logic                       salida_cero,
  output logic                       salida_negativo,
  output logic                       salida_desbordamiento,
  output logic [$clog2(DEPTH+1)-1:0] count,
  input  logic                       clear_sticky,
  output logic [3:0]                 salida_sticky
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  // Flags are packed {desbordamiento, negativo, cero, carry}, matching salida_sticky.
  typedef struct packed {
    logic [WIDTH-1:0] result;
    logic [3:0]       flags;
  } entry_t;

  entry_t          mem [DEPTH];
  entry_t          head;
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic [CW-1:0]   count_q;
  logic            full;
  logic            empty;
  logic            push;
  logic            pop;

  assign full     = (count_q == CW'(DEPTH));
  assign empty    = (count_q == '0);
  assign in_ready = !full;
  assign out_valid = !empty;

  // flush wins over any handshake in the same cycle, so both are masked by it.
  assign push = in_valid && !full && !flush;
  assign pop  = out_ready && !empty && !flush;

  // Storage: written only on an accepted push; cleared by reset so the head reads zero.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (push) begin
      mem[wr_ptr] <= '{result: in_result,
                       flags:  {in_desbordamiento, in_negativo, in_cero, in_carry}};
    end
  end

  // Pointers and occupancy; pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else if (flush) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      if (push && !pop)      count_q <= count_q + CW'(1);
      else if (pop && !push) count_q <= count_q - CW'(1);
    end
  end

  // Head comes straight from storage: no combinational path from in_* to salida_*.
  assign head                  = mem[rd_ptr];
  assign salida_result         = head.result;
  assign salida_carry          = head.flags[0];
  assign salida_cero           = head.flags[1];
  assign salida_negativo       = head.flags[2];
  assign salida_desbordamiento = head.flags[3];
  assign count                 = count_q;

`ifdef ALU_STICKY_FLAGS_EN
  logic [3:0] sticky_q;

  // Sticky flags: clear first, then accumulate the entry popped in the same cycle.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sticky_q <= '0;
    end else if (clear_sticky) begin
      sticky_q <= pop ? head.flags : 4'b0000;
    end else if (pop) begin
      sticky_q <= sticky_q | head.flags;
    end
  end

  assign salida_sticky = sticky_q;
`else
  logic unused_clear_sticky;

  assign unused_clear_sticky = clear_sticky;
  assign salida_sticky       = 4'b0000;
`endif

endmodule
